// File: rtl/timer_sched_pkg.sv
// Shared types and defaults for the timer scheduler: FSM state encoding and
// default requester count / countdown width.
package timer_sched_pkg;

  localparam int N_REQ_DEFAULT = 4;
  localparam int WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_e;

endpackage

// File: rtl/countdown_core.sv
// WIDTH-bit countdown counter: synchronous clear, load and saturating
// decrement (clear beats load beats decrement). busy flags a non-zero value.
module countdown_core #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  input  logic             clear,
  output logic [WIDTH-1:0] value,
  output logic             busy
);

  // Counter register; decrement holds at zero so the value never wraps.
  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (dec && (value != '0)) begin
      value <= value - 1'b1;
    end
  end

  assign busy = (value != '0);

endmodule

// File: rtl/timer_scheduler.sv
// Round-robin scheduler sharing one countdown timer among N_REQ requesters.
// A winner is picked in IDLE, the timer counts its duration down in RUN and a
// one-cycle done pulse is issued in DONE before returning to IDLE.
module timer_scheduler
  import timer_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] cycles,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [WIDTH-1:0]       remaining
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  sched_state_e     state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] owner_next;
  logic [IDX_W-1:0] winner;
  logic             any_req;
  logic [WIDTH-1:0] win_cycles;
  logic [N_REQ-1:0] owner_onehot;

  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_clear;
  logic             cnt_busy;
  logic [WIDTH-1:0] cnt_value;

  // Round-robin pick: first set req bit at or above ptr, wrapping. Scanning
  // from the far end down lets the closest candidate win by overwriting.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    winner  = '0;
    any_req = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[(int'(ptr_q) + i) % N_REQ]) begin
        winner  = IDX_W'((int'(ptr_q) + i) % N_REQ);
        any_req = 1'b1;
      end
    end
  end

  assign win_cycles   = cycles[int'(winner)*WIDTH +: WIDTH];
  assign owner_next   = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
  assign owner_onehot = N_REQ'(1) << owner_q;

  // Next-state, owner/pointer update and counter controls.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_clear = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d  = winner;
          cnt_load = 1'b1;
          state_d  = (win_cycles != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (!req[owner_q]) begin
          // Owner withdrew: silent abort, turn passes to the next index.
          state_d   = IDLE;
          cnt_clear = 1'b1;
          ptr_d     = owner_next;
        end else begin
          cnt_dec = cnt_busy;
          if (cnt_value <= WIDTH'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d   = IDLE;
        cnt_clear = 1'b1;
        ptr_d     = owner_next;
      end
      default: begin
        state_d   = IDLE;
        cnt_clear = 1'b1;
      end
    endcase
  end

  // State, owner and round-robin pointer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  countdown_core #(
    .WIDTH (WIDTH)
  ) u_countdown (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (cnt_load),
    .load_value (win_cycles),
    .dec        (cnt_dec),
    .clear      (cnt_clear),
    .value      (cnt_value),
    .busy       (cnt_busy)
  );

  assign busy      = (state_q != IDLE);
  assign grant     = busy ? owner_onehot : '0;
  assign done      = (state_q == DONE) ? owner_onehot : '0;
  assign remaining = cnt_value;

endmodule

// File: doc/timer_scheduler.md
TIMER_SCHEDULER -- requirements
Module: timer_scheduler

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the countdown timer (2..8).
REQ-002 Parameter WIDTH, default 16: countdown width in bits.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset_n  input  1  reset is synchronous and active-low.
REQ-005 req  input  N_REQ  per-requester request level, held until done or intentionally dropped.
REQ-006 cycles  input  N_REQ*WIDTH  per-requester duration; slice i = bits [i*WIDTH +: WIDTH].
REQ-007 grant  output  N_REQ  one-hot owner of the timer, all-zero when idle.
REQ-008 done  output  N_REQ  one-cycle completion pulse to the owner.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 remaining  output  WIDTH  current countdown value.

Function
REQ-011 FSM states IDLE, RUN, DONE; exactly one state active.
REQ-012 IDLE, no req bit set: stay IDLE, grant=0, remaining=0.
REQ-013 IDLE, any req set: at that edge select winner g by round-robin from index ptr upward (wrapping), set grant=onehot(g), remaining=cycles[g].
REQ-014 From IDLE, next state is RUN if cycles[g]>0, else DONE (zero-length request completes without RUN).
REQ-015 cycles[g] sampled only at the grant edge; later changes ignored.
REQ-016 RUN: remaining decrements by 1 per edge; on the edge where remaining goes 1->0, next state DONE.
REQ-017 remaining is unsigned and never wraps; it never decrements below 0.
REQ-018 DONE: done[g]=1 for exactly that cycle, grant held; next edge -> IDLE, grant=0, ptr=(g+1) mod N_REQ.
REQ-019 Latency: grant edge E0 with cycles C>0 -> remaining=0 and done visible after edge E0+C; IDLE after E0+C+1.
REQ-020 Abort: req[g] low while in RUN -> next edge IDLE, remaining=0, grant=0, no done pulse, ptr=(g+1) mod N_REQ.
REQ-021 req[g] low during DONE has no effect; done still pulses.
REQ-022 Requests from non-owners while busy are held pending, never dropped or granted early.
REQ-023 Owner keeping req high through DONE is a new request and competes under round-robin from the updated ptr.
REQ-024 No arbitration in DONE; at least one IDLE cycle between consecutive grants.
REQ-025 grant is one-hot or zero; done is a subset of grant; at most one done bit per cycle.

Reset
REQ-026 reset_n low at a clock edge: state IDLE, ptr=0, remaining=0, grant=0, done=0, busy=0.
REQ-027 Reset mid-RUN or mid-DONE aborts silently; no done pulse is emitted.
REQ-028 Reset overrides req and all FSM transitions.

Structure
REQ-029 Shared package timer_sched_pkg holds the state enum (IDLE, RUN, DONE) and default N_REQ and WIDTH constants.
REQ-030 One sub-module, countdown_core (WIDTH-bit load/decrement/clear counter with busy = value>0), instantiated once; arbitration and FSM stay in timer_scheduler.
REQ-031 Round-robin selection is a combinational function of req and ptr, registered only through grant.

Verification
REQ-032 Single: reset, req[1]=1, cycles[1]=3 -> grant=0010 next edge, remaining 3,2,1,0, done[1] pulses 3 cycles after grant, IDLE next cycle.
REQ-033 Fairness: req=1111 held, all cycles=2 -> grants in order 0,1,2,3,0, each done exactly once per round.
REQ-034 Zero length: req[2]=1, cycles[2]=0 -> grant=0100 and done[2]=1 in the same cycle, busy for 1 cycle.
REQ-035 Abort: req[0] cycles=10, drop req[0] after 4 RUN cycles -> IDLE next edge, remaining=0, no done; pending req[3] granted next.
REQ-036 Reset mid-RUN: req[1] cycles=8, reset_n low after 3 cycles -> all outputs 0 next edge, no done; then req[0] and req[1] both high -> grant=0001 (ptr=0).
REQ-037 Formal properties on every cycle: grant one-hot-or-zero, done subset of grant, busy == (state != IDLE), remaining never increments except at a grant edge.
